// File: rtl/edge_pulse_pkg.sv
// Shared types and helpers for the edge_pulse_bank input conditioner.
`timescale 1ns/1ps
package edge_pulse_pkg;

    // Which debounced edge produces a pulse.
    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    // Per-channel debounce state: stable low/high, or waiting for a change to settle.
    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_PEND = 2'd1,
        HIGH      = 2'd2,
        FALL_PEND = 2'd3
    } chan_state_e;

    // Width needed for a counter that holds 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_pulse_chan.sv
// One conditioner channel: synchroniser chain, debounce counter, state
// machine and pulse generation. The auto-repeat counter exists only when
// EDGE_PULSE_REPEAT_EN is defined.
`timescale 1ns/1ps
module edge_pulse_chan
    import edge_pulse_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int EDGE_MODE       = 0,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level_in,
    output logic level_out,
    output logic pulse_out
);

    localparam int              CW         = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam edge_mode_e      MODE       = edge_mode_e'(2'(EDGE_MODE));
    localparam bit              PULSE_RISE = (MODE == EDGE_RISE) || (MODE == EDGE_BOTH);
    localparam bit              PULSE_FALL = (MODE == EDGE_FALL) || (MODE == EDGE_BOTH);

    // Reject parameter sets the logic below cannot honour.
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1
        || EDGE_MODE < 0 || EDGE_MODE > 2) begin : gen_bad_param
        $error("edge_pulse_chan: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    chan_state_e            state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   level_reg, level_next;
    logic                   pulse_reg, pulse_next;
    logic                   deb_done;
    logic                   edge_pulse;
    logic                   rep_pulse;

    assign s = sync_reg[SYNC_STAGES-1];

    // Debounce finishes on the edge where the differing sample count reaches the window.
    assign deb_done = (s != level_reg) && (cnt_reg == CNT_LAST);

    // Synchroniser shift chain for the asynchronous pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], level_in};
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LOW;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            pulse_reg <= pulse_next;
        end
    end

    // Next-state: a pending change either completes or collapses back on a glitch.
    // With a one-sample window the change completes directly from the stable state.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOW:       if (s)  state_next = deb_done ? HIGH : RISE_PEND;
            RISE_PEND: if (!s) state_next = LOW;
                       else if (deb_done) state_next = HIGH;
            HIGH:      if (!s) state_next = deb_done ? LOW : FALL_PEND;
            FALL_PEND: if (s)  state_next = HIGH;
                       else if (deb_done) state_next = LOW;
            default:   state_next = LOW;
        endcase
    end

    // Output/datapath next values: counter, debounced level and the pulse.
    always_comb begin
        cnt_next   = cnt_reg + CW'(1);
        if ((s == level_reg) || deb_done) begin
            cnt_next = '0;
        end
        level_next = deb_done ? ~level_reg : level_reg;
        edge_pulse = deb_done && ((!level_reg && PULSE_RISE) || (level_reg && PULSE_FALL));
        pulse_next = edge_pulse | rep_pulse;
    end

`ifdef EDGE_PULSE_REPEAT_EN
    localparam int            REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW      = cnt_width(REP_MAX + 1);
    localparam logic [RW-1:0] REP_DLY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_PER = RW'(REPEAT_PERIOD);

    logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
    logic          rep_phase_reg, rep_phase_next;
    logic [RW-1:0] rep_target;

    // Repeat timer: first target is the initial delay, then the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_reg   <= '0;
            rep_phase_reg <= 1'b0;
        end else begin
            rep_cnt_reg   <= rep_cnt_next;
            rep_phase_reg <= rep_phase_next;
        end
    end

    // Counts only while staying in HIGH; pending-fall holds it, LOW clears it.
    always_comb begin
        rep_cnt_next   = rep_cnt_reg;
        rep_phase_next = rep_phase_reg;
        rep_pulse      = 1'b0;
        rep_target     = rep_phase_reg ? REP_PER : REP_DLY;
        if (state_reg == LOW) begin
            rep_cnt_next   = '0;
            rep_phase_next = 1'b0;
        end else if (PULSE_RISE && (state_reg == HIGH) && (state_next == HIGH)) begin
            if ((rep_cnt_reg + RW'(1)) == rep_target) begin
                rep_cnt_next   = '0;
                rep_phase_next = 1'b1;
                rep_pulse      = 1'b1;
            end else begin
                rep_cnt_next = rep_cnt_reg + RW'(1);
            end
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    assign level_out = level_reg;
    assign pulse_out = pulse_reg;

endmodule

// File: rtl/edge_pulse_bank.sv
// edge_pulse_bank: CH independent synchronise/debounce/edge-pulse channels.
// Optional auto-repeat on held inputs is built when EDGE_PULSE_REPEAT_EN is defined.
`timescale 1ns/1ps
module edge_pulse_bank
    import edge_pulse_pkg::*;
#(
    parameter int CH              = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int EDGE_MODE       = 0,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] level_in,
    output logic [CH-1:0] level_out,
    output logic [CH-1:0] pulse_out
);

    genvar gi;
    // One self-contained conditioner per input pin.
    generate
        for (gi = 0; gi < CH; gi++) begin : gen_chan
            edge_pulse_chan #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .EDGE_MODE       (EDGE_MODE),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .level_in  (level_in[gi]),
                .level_out (level_out[gi]),
                .pulse_out (pulse_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_edge_pulse_bank.sv
`timescale 1ns/1ps
module tb_edge_pulse_bank;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] lin_r = 2'b00;
    logic [1:0] lin_b = 2'b00;
    logic [1:0] lout_r, pout_r, lout_b, pout_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [1:0] pulse;
    } exp_t;

    exp_t q_r[$];
    exp_t q_b[$];

    // Rise-mode bank (repeat 10/5 when the repeat feature is built).
    edge_pulse_bank #(
        .CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) dut_r (
        .clk(clk), .rst_n(rst_n), .level_in(lin_r), .level_out(lout_r), .pulse_out(pout_r)
    );

    // Both-edge bank; repeat pushed far out of reach of these tests.
    edge_pulse_bank #(
        .CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2),
        .REPEAT_DELAY(1000), .REPEAT_PERIOD(1000)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .level_in(lin_b), .level_out(lout_b), .pulse_out(pout_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_r(input int at, input logic [1:0] p);
        exp_t e;
        e.cyc = at;
        e.pulse = p;
        q_r.push_back(e);
    endtask

    task automatic push_b(input int at, input logic [1:0] p);
        exp_t e;
        e.cyc = at;
        e.pulse = p;
        q_b.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int c;
        logic [1:0] exp_l;
        rst_n = 1'b0;
        lin_r = 2'b10;
        lin_b = 2'b00;
        wait_cyc(3);
        checks++;
        if (lout_r !== 2'b00) begin errors++; $display("FAIL reset_level_r got=%b exp=00", lout_r); end
        checks++;
        if (pout_r !== 2'b00) begin errors++; $display("FAIL reset_pulse_r got=%b exp=00", pout_r); end
        checks++;
        if (lout_b !== 2'b00) begin errors++; $display("FAIL reset_level_b got=%b exp=00", lout_b); end
        checks++;
        if (pout_b !== 2'b00) begin errors++; $display("FAIL reset_pulse_b got=%b exp=00", pout_b); end
        // Input held high through reset: one rise pulse after normal latency.
        rst_n = 1'b1;
        c = cyc;
        push_r(c + 6, 2'b10);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_l = (i >= 6) ? 2'b10 : 2'b00;
            checks++;
            if (lout_r !== exp_l) begin errors++; $display("FAIL reset_held_level i=%0d got=%b exp=%b", i, lout_r, exp_l); end
        end
        lin_r = 2'b00;
        wait_cyc(10);
        checks++;
        if (lout_r !== 2'b00) begin errors++; $display("FAIL reset_held_release got=%b exp=00", lout_r); end
        $display("test_reset done");
    endtask

    task automatic test_clean_rise();
        int c;
        logic [1:0] exp_l;
        c = cyc;
        lin_r[0] = 1'b1;
        push_r(c + 6, 2'b01);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_l = (i >= 6) ? 2'b01 : 2'b00;
            checks++;
            if (lout_r !== exp_l) begin errors++; $display("FAIL clean_rise_level i=%0d got=%b exp=%b", i, lout_r, exp_l); end
        end
        lin_r[0] = 1'b0;
        wait_cyc(8);
        checks++;
        if (lout_r !== 2'b00) begin errors++; $display("FAIL clean_rise_release got=%b exp=00", lout_r); end
        $display("test_clean_rise done");
    endtask

    task automatic test_glitch();
        lin_r[0] = 1'b1;
        wait_cyc(3);
        lin_r[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (lout_r !== 2'b00) begin errors++; $display("FAIL glitch_level i=%0d got=%b exp=00", i, lout_r); end
        end
        checks++;
        if (dut_r.gen_chan[0].u_chan.cnt_reg !== 2'd0) begin
            errors++;
            $display("FAIL glitch_cnt got=%0d exp=0", dut_r.gen_chan[0].u_chan.cnt_reg);
        end
        $display("test_glitch done");
    endtask

    task automatic test_both_edge();
        int c;
        logic [1:0] exp_l;
        c = cyc;
        lin_b[0] = 1'b1;
        push_b(c + 6, 2'b01);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            exp_l = (i >= 6 && i < 26) ? 2'b01 : 2'b00;
            checks++;
            if (lout_b !== exp_l) begin errors++; $display("FAIL both_edge_level i=%0d got=%b exp=%b", i, lout_b, exp_l); end
            if (i == 20) begin
                lin_b[0] = 1'b0;
                push_b(c + 26, 2'b01);
            end
        end
        wait_cyc(4);
        $display("test_both_edge done");
    endtask

    task automatic test_reset_mid();
        int c;
        int d;
        logic [1:0] exp_l;
        // Settle channel 1 high first so the reset has something visible to clear.
        c = cyc;
        lin_r[1] = 1'b1;
        push_r(c + 6, 2'b10);
        wait_cyc(8);
        lin_r[0] = 1'b1;
        wait_cyc(3);
        rst_n = 1'b0;
        #1;
        checks++;
        if (lout_r !== 2'b00) begin errors++; $display("FAIL reset_mid_level_r got=%b exp=00", lout_r); end
        checks++;
        if (pout_r !== 2'b00) begin errors++; $display("FAIL reset_mid_pulse_r got=%b exp=00", pout_r); end
        checks++;
        if (lout_b !== 2'b00) begin errors++; $display("FAIL reset_mid_level_b got=%b exp=00", lout_b); end
        checks++;
        if (pout_b !== 2'b00) begin errors++; $display("FAIL reset_mid_pulse_b got=%b exp=00", pout_b); end
        @(negedge clk);
        rst_n = 1'b1;
        d = cyc;
        push_r(d + 6, 2'b11);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            exp_l = (i >= 6) ? 2'b11 : 2'b00;
            checks++;
            if (lout_r !== exp_l) begin errors++; $display("FAIL reset_mid_relevel i=%0d got=%b exp=%b", i, lout_r, exp_l); end
        end
        lin_r = 2'b00;
        wait_cyc(10);
        $display("test_reset_mid done");
    endtask

    task automatic test_independence();
        int c;
        logic [1:0] exp_l;
        c = cyc;
        lin_b[1] = 1'b1;
        push_b(c + 6, 2'b10);
        wait_cyc(8);
        c = cyc;
        lin_b = 2'b01;
        push_b(c + 6, 2'b11);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_l = (i >= 6) ? 2'b01 : 2'b10;
            checks++;
            if (lout_b !== exp_l) begin errors++; $display("FAIL indep_level i=%0d got=%b exp=%b", i, lout_b, exp_l); end
        end
        c = cyc;
        lin_b = 2'b00;
        push_b(c + 6, 2'b01);
        wait_cyc(9);
        $display("test_independence done");
    endtask

`ifdef EDGE_PULSE_REPEAT_EN
    task automatic test_repeat();
        int c;
        logic [1:0] exp_l;
        c = cyc;
        lin_r[0] = 1'b1;
        push_r(c + 6,  2'b01);
        push_r(c + 16, 2'b01);
        push_r(c + 21, 2'b01);
        push_r(c + 26, 2'b01);
        push_r(c + 31, 2'b01);
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            exp_l = (i >= 6 && i < 36) ? 2'b01 : 2'b00;
            checks++;
            if (lout_r !== exp_l) begin errors++; $display("FAIL repeat_level i=%0d got=%b exp=%b", i, lout_r, exp_l); end
            if (i == 30) lin_r[0] = 1'b0;
        end
        $display("test_repeat done");
    endtask
`endif

    initial begin
        // Scoreboard: every cycle, a due expectation is popped and compared;
        // any pulse with nothing due is unexpected.
        fork
            forever begin : scoreboard
                exp_t e;
                @(negedge clk);
                if (q_r.size() > 0 && q_r[0].cyc == cyc) begin
                    e = q_r.pop_front();
                    checks++;
                    if (pout_r !== e.pulse) begin
                        errors++;
                        $display("FAIL pulse_r cyc=%0d got=%b exp=%b", cyc, pout_r, e.pulse);
                    end else begin
                        $display("pulse_r cyc=%0d value=%b ok", cyc, pout_r);
                    end
                end else if (pout_r !== 2'b00) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_r_unexpected cyc=%0d got=%b exp=00", cyc, pout_r);
                end
                if (q_b.size() > 0 && q_b[0].cyc == cyc) begin
                    e = q_b.pop_front();
                    checks++;
                    if (pout_b !== e.pulse) begin
                        errors++;
                        $display("FAIL pulse_b cyc=%0d got=%b exp=%b", cyc, pout_b, e.pulse);
                    end else begin
                        $display("pulse_b cyc=%0d value=%b ok", cyc, pout_b);
                    end
                end else if (pout_b !== 2'b00) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_b_unexpected cyc=%0d got=%b exp=00", cyc, pout_b);
                end
            end
        join_none

        test_reset();
        test_clean_rise();
        test_glitch();
        test_both_edge();
        test_reset_mid();
        test_independence();
`ifdef EDGE_PULSE_REPEAT_EN
        test_repeat();
`endif
        wait_cyc(2);
        checks++;
        if (q_r.size() != 0) begin errors++; $display("FAIL missing_pulses_r got=%0d pending exp=0", q_r.size()); end
        checks++;
        if (q_b.size() != 0) begin errors++; $display("FAIL missing_pulses_b got=%0d pending exp=0", q_b.size()); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
